// File: rtl/ahb_master.sv
// -----------------------------------------------------------------------------
// ahb_master
//
// Purpose:
//   A single-command AHB-Lite master. It accepts one command at a time and runs
//   it as a SINGLE, INCR4 or WRAP4 byte transfer. Burst beats are pipelined, so
//   the address phase of beat k overlaps the data phase of beat k-1. An ERROR
//   response cancels the remaining beats and ends the command with err set.
//
// Ports:
//   hclk, hresetn      bus clock (rising edge) and asynchronous active-low reset
//   start              command request, sampled only while busy=0
//   cmd_write          1=write, 0=read
//   cmd_addr           start address
//   cmd_burst          000 SINGLE, 010 WRAP4, 011 INCR4 (other codes run as SINGLE)
//   cmd_wdata          four write beats; beat k in bits [DATA_W*k +: DATA_W]
//   busy               a command is in progress
//   done               one-cycle completion pulse
//   err                last command ended on an ERROR response (held to next start)
//   rd_data            four read beats, packed like cmd_wdata
//   hsel .. hwdata     AHB master-side outputs
//   hready, hresp,     AHB slave responses
//   hrdata
// -----------------------------------------------------------------------------
module ahb_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  start,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [2:0]            cmd_burst,
  input  logic [4*DATA_W-1:0]   cmd_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [4*DATA_W-1:0]   rd_data,
  output logic                  hsel,
  output logic [ADDR_W-1:0]     haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [1:0]            htrans,
  output logic                  hmastlock,
  output logic [DATA_W-1:0]     hwdata,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [DATA_W-1:0]     hrdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PIPE,
    S_DATA,
    S_FIN
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_WRAP4  = 3'b010;
  localparam logic [2:0] HB_INCR4  = 3'b011;

  // ---------------------------------------------------------------------------
  // State and latched command
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic                r_write;
  logic [2:0]          r_burst;
  logic [4*DATA_W-1:0] r_wbeats;
  logic [1:0]          r_abeat;    // beat currently in its address phase (PIPE)
  logic [1:0]          r_dbeat;    // beat currently in its data phase
  logic                r_abort;    // ERROR seen; remaining beats cancelled

  // Registered outputs
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [4*DATA_W-1:0] r_rd_data;
  logic                r_hsel;
  logic [ADDR_W-1:0]   r_haddr;
  logic                r_hwrite;
  logic [2:0]          r_hburst;
  logic [1:0]          r_htrans;
  logic [DATA_W-1:0]   r_hwdata;

  // ---------------------------------------------------------------------------
  // Per-beat address and write-data tables for the latched command
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]   w_beat_addr [4];
  logic [DATA_W-1:0]   w_wbeat     [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_beat
    // WRAP4 only rolls the low two address bits; INCR4 carries through the
    // whole address and is allowed to wrap past the top of the address space.
    assign w_beat_addr[gi] = (r_burst == HB_WRAP4)
                           ? {r_base[ADDR_W-1:2], r_base[1:0] + 2'(gi)}
                           : r_base + ADDR_W'(gi);
    // Reads present zero on hwdata so the bus never shows stale write data.
    assign w_wbeat[gi] = r_write ? r_wbeats[DATA_W*gi +: DATA_W] : '0;
  end

  // Unsupported burst codes are executed (and shown on hburst) as SINGLE.
  logic [2:0] w_cmd_burst;
  assign w_cmd_burst = ((cmd_burst == HB_WRAP4) || (cmd_burst == HB_INCR4))
                     ? cmd_burst : HB_SINGLE;

  logic [1:0] w_abeat_inc;
  assign w_abeat_inc = r_abeat + 2'd1;

  // A read data phase finishes with good data only on hready with OKAY.
  logic w_capture;
  assign w_capture = !r_write && hready && !hresp;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_write   <= 1'b0;
      r_burst   <= HB_SINGLE;
      r_wbeats  <= '0;
      r_abeat   <= 2'd0;
      r_dbeat   <= 2'd0;
      r_abort   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      r_hsel    <= 1'b0;
      r_haddr   <= '0;
      r_hwrite  <= 1'b0;
      r_hburst  <= 3'b000;
      r_htrans  <= HT_IDLE;
      r_hwdata  <= '0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base   <= cmd_addr;
            r_write  <= cmd_write;
            r_burst  <= w_cmd_burst;
            r_wbeats <= cmd_wdata;
            r_abort  <= 1'b0;
            r_busy   <= 1'b1;
            r_err    <= 1'b0;
            r_hsel   <= 1'b1;
            r_haddr  <= cmd_addr;
            r_hwrite <= cmd_write;
            r_hburst <= w_cmd_burst;
            r_htrans <= HT_NONSEQ;
            r_state  <= S_ADDR;
          end
        end

        // Beat 0 address phase. No data phase is outstanding here, so hresp
        // has nothing to refer to and is ignored.
        S_ADDR: begin
          if (hready) begin
            r_dbeat  <= 2'd0;
            r_hwdata <= w_wbeat[0];
            if (r_burst == HB_SINGLE) begin
              r_htrans <= HT_IDLE;
              r_state  <= S_DATA;
            end else begin
              r_abeat  <= 2'd1;
              r_haddr  <= w_beat_addr[1];
              r_htrans <= HT_SEQ;
              r_state  <= S_PIPE;
            end
          end
        end

        // Address phase of beat r_abeat overlapping data phase of r_dbeat.
        S_PIPE: begin
          if (hresp) begin
            // Cancel the pending address phase. If the slave is still in the
            // first ERROR cycle the data phase continues, so hwdata is kept.
            r_abort  <= 1'b1;
            r_htrans <= HT_IDLE;
            r_state  <= S_DATA;
            if (hready) begin
              r_hwdata <= '0;
            end
          end else if (hready) begin
            if (w_capture) begin
              r_rd_data[DATA_W*r_dbeat +: DATA_W] <= hrdata;
            end
            r_dbeat  <= r_abeat;
            r_hwdata <= w_wbeat[r_abeat];
            if (r_abeat == 2'd3) begin
              r_htrans <= HT_IDLE;
              r_state  <= S_DATA;
            end else begin
              r_abeat  <= w_abeat_inc;
              r_haddr  <= w_beat_addr[w_abeat_inc];
            end
          end
        end

        // Final data phase, or the tail of an ERROR response when aborting.
        S_DATA: begin
          if (hready) begin
            if (w_capture && !r_abort) begin
              r_rd_data[DATA_W*r_dbeat +: DATA_W] <= hrdata;
            end
            r_err    <= r_abort | hresp;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_hsel   <= 1'b0;
            r_hwdata <= '0;
            r_state  <= S_FIN;
          end else if (hresp) begin
            r_abort <= 1'b1;
          end
        end

        // done is high for this one cycle; start is deliberately not sampled.
        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rd_data   = r_rd_data;
  assign hsel      = r_hsel;
  assign haddr     = r_haddr;
  assign hwrite    = r_hwrite;
  assign hburst    = r_hburst;
  assign htrans    = r_htrans;
  assign hwdata    = r_hwdata;
  assign hsize     = 3'b000;
  assign hprot     = 4'b0011;
  assign hmastlock = 1'b0;

endmodule
